// File: rtl/rs_chien_seq.sv
// rs_chien_seq: multi-cycle Chien search, PAR_NUM locator evaluations per cycle.
// Optional early exit once roots found equal degree: RS_CHIEN_EARLY_EXIT_EN.
package gf_pkg;
  localparam int SYMB_WIDTH = 8;
  localparam int SYMB_NUM = 1 << SYMB_WIDTH;
  localparam int T_LEN = 8;
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef logic [T_LEN:0][SYMB_WIDTH-1:0] poly_t;

  function automatic symb_t gf_mul(input symb_t a, input symb_t b);
    symb_t r;
    symb_t s;
    r = '0;
    s = a;
    for (int n = 0; n < SYMB_WIDTH; n++) begin
      if (b[n]) r = r ^ s;
      if (s[SYMB_WIDTH-1])
        s = (s << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0];
      else
        s = s << 1;
    end
    return r;
  endfunction

  function automatic symb_t alpha_to_symb(input int i);
    symb_t r;
    r = symb_t'(1);
    for (int n = 0; n < SYMB_NUM - 1; n++)
      if (n < i) r = gf_mul(r, symb_t'(2));
    return r;
  endfunction

  function automatic symb_t gf_poly_eval(input poly_t p, input symb_t x);
    symb_t acc;
    acc = '0;
    for (int j = T_LEN; j >= 0; j--)
      acc = gf_mul(acc, x) ^ p[j];
    return acc;
  endfunction
endpackage

module rs_chien_seq
  import gf_pkg::*;
#(
  parameter int PAR_NUM = 4
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]     error_locator,
  input  logic                               error_locator_vld,
  output logic                               error_locator_rdy,
  output logic [SYMB_NUM-2:0]                error_positions,
  output logic [$clog2(T_LEN+1)-1:0]         root_cnt,
  output logic                               decode_fail,
  output logic                               error_positions_vld,
  input  logic                               error_positions_rdy
);
  localparam int CNT_W = $clog2(T_LEN + 1);
  localparam int IDX_W = $clog2(2 * SYMB_NUM);
  localparam int POS_W = $clog2(SYMB_NUM - 1);
  localparam int SUM_W = $clog2(2 * (T_LEN + 1) + PAR_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SYMB_NUM - 1);
  localparam symb_t ALPHA_P = alpha_to_symb(PAR_NUM);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  state_e state_q, state_d;
  poly_t poly_q, poly_d;
  logic [CNT_W-1:0] deg_q, deg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  symb_t x_q [PAR_NUM];
  symb_t x_d [PAR_NUM];
  logic [SYMB_NUM-2:0] bitmap_q, bitmap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fail_q, fail_d;

  logic [PAR_NUM-1:0] hit;
  logic [IDX_W-1:0] lane_i [PAR_NUM];
  logic [POS_W-1:0] pos [PAR_NUM];
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] deg_in;
  logic last_iter;
  logic search_end;
  logic accept;

  // Per-lane root test; lanes past the last field element are masked.
  always_comb begin
    hit = '0;
    for (int k = 0; k < PAR_NUM; k++) begin
      lane_i[k] = idx_q + IDX_W'(k);
      pos[k] = POS_W'(SYMB_NUM - 2) - lane_i[k][POS_W-1:0];
      if (lane_i[k] < LAST && gf_poly_eval(poly_q, x_q[k]) == '0)
        hit[k] = 1'b1;
    end
  end

  // Saturating root count including this cycle's hits.
  always_comb begin
    sum = SUM_W'(cnt_q);
    for (int k = 0; k < PAR_NUM; k++)
      sum = sum + SUM_W'(hit[k]);
    if (sum > SUM_W'(CNT_MAX))
      cnt_sat = CNT_MAX;
    else
      cnt_sat = sum[CNT_W-1:0];
    last_iter = (idx_q + IDX_W'(PAR_NUM)) >= LAST;
  end

  // Degree of the incoming locator: highest nonzero coefficient.
  always_comb begin
    deg_in = '0;
    for (int j = 1; j <= T_LEN; j++)
      if (error_locator[j] != '0) deg_in = CNT_W'(j);
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    error_locator_rdy = 1'b0;
    error_positions_vld = 1'b0;
    search_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        error_locator_rdy = 1'b1;
        if (error_locator_vld) state_d = SEARCH;
      end
      SEARCH: begin
        search_end = last_iter;
`ifdef RS_CHIEN_EARLY_EXIT_EN
        if (cnt_sat >= deg_q) search_end = 1'b1;
`else
        search_end = last_iter;
`endif
        if (search_end) state_d = DONE;
      end
      DONE: begin
        error_positions_vld = 1'b1;
        if (error_positions_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = error_locator_rdy & error_locator_vld;

  // Datapath next state: load on accept, step evaluators during search.
  always_comb begin
    poly_d = poly_q;
    deg_d = deg_q;
    idx_d = idx_q;
    x_d = x_q;
    bitmap_d = bitmap_q;
    cnt_d = cnt_q;
    fail_d = fail_q;
    if (accept) begin
      poly_d = error_locator;
      deg_d = deg_in;
      idx_d = '0;
      bitmap_d = '0;
      cnt_d = '0;
      fail_d = 1'b0;
      for (int k = 0; k < PAR_NUM; k++)
        x_d[k] = alpha_to_symb(k);
    end else if (state_q == SEARCH) begin
      idx_d = idx_q + IDX_W'(PAR_NUM);
      cnt_d = cnt_sat;
      for (int k = 0; k < PAR_NUM; k++) begin
        x_d[k] = gf_mul(x_q[k], ALPHA_P);
        if (hit[k]) bitmap_d[pos[k]] = 1'b1;
      end
      if (search_end) fail_d = (cnt_sat != deg_q);
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      poly_q <= '0;
      deg_q <= '0;
      idx_q <= '0;
      bitmap_q <= '0;
      cnt_q <= '0;
      fail_q <= 1'b0;
      for (int k = 0; k < PAR_NUM; k++) x_q[k] <= '0;
    end else begin
      poly_q <= poly_d;
      deg_q <= deg_d;
      idx_q <= idx_d;
      bitmap_q <= bitmap_d;
      cnt_q <= cnt_d;
      fail_q <= fail_d;
      for (int k = 0; k < PAR_NUM; k++) x_q[k] <= x_d[k];
    end
  end

  assign error_positions = bitmap_q;
  assign root_cnt = cnt_q;
  assign decode_fail = fail_q;
endmodule

// File: tb/tb_rs_chien_seq.sv
// tb_rs_chien_seq: randomized scenarios against a table-based GF(2^8) model.
// Latency is counted in cycles with the accept cycle as cycle 0.
`timescale 1ns/1ps
module tb_rs_chien_seq;
  localparam int SW = 8;
  localparam int SN = 256;
  localparam int TL = 8;
  localparam int PAR = 4;
  localparam int NP = SN - 1;
  localparam int ITER = (NP + PAR - 1) / PAR;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef logic [TL:0][SW-1:0] poly_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  poly_t error_locator = '0;
  logic error_locator_vld = 1'b0;
  logic error_locator_rdy;
  logic [SN-2:0] error_positions;
  logic [CW-1:0] root_cnt;
  logic decode_fail;
  logic error_positions_vld;
  logic error_positions_rdy = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int gexp [0:254];
  int glog [0:255];

  always #5 aclk = ~aclk;

  rs_chien_seq #(.PAR_NUM(PAR)) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .error_locator(error_locator),
    .error_locator_vld(error_locator_vld),
    .error_locator_rdy(error_locator_rdy),
    .error_positions(error_positions),
    .root_cnt(root_cnt),
    .decode_fail(decode_fail),
    .error_positions_vld(error_positions_vld),
    .error_positions_rdy(error_positions_rdy)
  );

  task automatic init_tables();
    int v;
    v = 1;
    for (int n = 0; n < 255; n++) begin
      gexp[n] = v;
      glog[v] = n;
      v = v << 1;
      if (v > 255) v = v ^ 'h11D;
    end
    glog[0] = 0;
  endtask

  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Sum of c_j * alpha^(i*j) computed through log/antilog tables.
  function automatic int peval(poly_t p, int i);
    int v;
    v = 0;
    for (int j = 0; j <= TL; j++)
      if (p[j] != 0) v = v ^ gexp[(glog[int'(p[j])] + i * j) % 255];
    return v;
  endfunction

  task automatic model(input poly_t p, output logic [SN-2:0] bm,
                       output int cnt, output bit fl, output int lat);
    int deg, cyc, c;
    bit found;
    deg = 0;
    for (int j = 1; j <= TL; j++) if (p[j] != 0) deg = j;
    bm = '0;
    c = 0;
    cyc = ITER;
    found = 0;
    for (int i = 0; i < NP; i++) begin
      if (peval(p, i) == 0) begin
        bm[SN - 2 - i] = 1'b1;
        c++;
      end
`ifdef RS_CHIEN_EARLY_EXIT_EN
      if (!found && ((i + 1) % PAR == 0 || i == NP - 1) && c >= deg) begin
        found = 1;
        cyc = i / PAR + 1;
      end
`endif
    end
    cnt = (c > CMAX) ? CMAX : c;
    fl = (cnt != deg);
    lat = cyc + 1;
  endtask

  function automatic poly_t rand_locator(int deg);
    poly_t p;
    bit used [0:254];
    int r, a;
    p = '0;
    p[0] = 8'd1;
    for (int n = 0; n < 255; n++) used[n] = 0;
    for (int d = 0; d < deg; d++) begin
      do r = $urandom_range(0, 254); while (used[r]);
      used[r] = 1;
      a = gexp[(255 - r) % 255];
      for (int j = TL; j >= 1; j--)
        p[j] = p[j] ^ SW'(gmul(a, int'(p[j-1])));
    end
    return p;
  endfunction

  task automatic run(input poly_t p, output logic [SN-2:0] bm,
                     output int cnt, output bit fl, output int lat);
    int g;
    @(negedge aclk);
    error_locator = p;
    error_locator_vld = 1'b1;
    g = 0;
    while (!error_locator_rdy && g < 200) begin
      @(negedge aclk);
      g++;
    end
    @(posedge aclk);
    #1;
    error_locator_vld = 1'b0;
    for (int j = 0; j <= TL; j++) error_locator[j] = SW'($urandom);
    lat = 1;
    @(negedge aclk);
    while (!error_positions_vld && lat < 400) begin
      @(negedge aclk);
      lat++;
    end
    bm = error_positions;
    cnt = int'(root_cnt);
    fl = decode_fail;
  endtask

  task automatic drain();
    @(negedge aclk);
    error_positions_rdy = 1'b1;
    @(posedge aclk);
    #1;
    error_positions_rdy = 1'b0;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_chk++; if (error_locator_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b want 1", error_locator_rdy); end
    n_chk++; if (error_positions_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", error_positions_vld); end
    n_chk++; if (error_positions !== '0) begin n_fail++; $display("FAIL reset_pos got %h want 0", error_positions); end
    n_chk++; if (root_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", root_cnt); end
    n_chk++; if (decode_fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail got %b want 0", decode_fail); end
    aresetn = 1'b1;
  endtask

  task automatic test_fixed(input string nm, input poly_t p);
    logic [SN-2:0] bm, ebm;
    int cnt, ecnt, lat, elat;
    bit fl, efl;
    model(p, ebm, ecnt, efl, elat);
    run(p, bm, cnt, fl, lat);
    n_chk++; if (bm !== ebm) begin n_fail++; $display("FAIL %s_pos got %h want %h", nm, bm, ebm); end
    n_chk++; if (cnt !== ecnt) begin n_fail++; $display("FAIL %s_cnt got %0d want %0d", nm, cnt, ecnt); end
    n_chk++; if (fl !== efl) begin n_fail++; $display("FAIL %s_fail got %b want %b", nm, fl, efl); end
    n_chk++; if (lat !== elat) begin n_fail++; $display("FAIL %s_lat got %0d want %0d", nm, lat, elat); end
    drain();
    n_chk++; if (error_positions_vld !== 1'b0 || error_locator_rdy !== 1'b1) begin n_fail++; $display("FAIL %s_handoff got vld=%b rdy=%b want vld=0 rdy=1", nm, error_positions_vld, error_locator_rdy); end
  endtask

  task automatic test_degree0();
    poly_t p;
    p = '0;
    p[0] = 8'd1;
    test_fixed("deg0", p);
  endtask

  task automatic test_single_root();
    poly_t p;
    logic [SN-2:0] bm, want;
    int cnt, lat;
    bit fl;
    p = '0;
    p[0] = 8'd1;
    p[1] = SW'(gexp[245]);
    want = '0;
    want[244] = 1'b1;
    run(p, bm, cnt, fl, lat);
    n_chk++; if (bm !== want) begin n_fail++; $display("FAIL single_pos got %h want %h", bm, want); end
    n_chk++; if (cnt !== 1 || fl !== 1'b0) begin n_fail++; $display("FAIL single_cnt got cnt=%0d fail=%b want cnt=1 fail=0", cnt, fl); end
`ifdef RS_CHIEN_EARLY_EXIT_EN
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL single_lat got %0d want 4", lat); end
`else
    n_chk++; if (lat !== ITER + 1) begin n_fail++; $display("FAIL single_lat got %0d want %0d", lat, ITER + 1); end
`endif
    drain();
  endtask

  task automatic test_double_root();
    poly_t p;
    p = '0;
    p[0] = 8'd1;
    p[2] = 8'd1;
    test_fixed("dbl", p);
  endtask

  task automatic test_backpressure();
    logic [SN-2:0] bm, ebm;
    int cnt, ecnt, lat, elat, bad;
    bit fl, efl;
    poly_t p;
    p = rand_locator(3);
    model(p, ebm, ecnt, efl, elat);
    run(p, bm, cnt, fl, lat);
    n_chk++; if (bm !== ebm || cnt !== ecnt) begin n_fail++; $display("FAIL bp_result got %h/%0d want %h/%0d", bm, cnt, ebm, ecnt); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (error_positions_vld !== 1'b1 || error_locator_rdy !== 1'b0 ||
          error_positions !== ebm || int'(root_cnt) !== ecnt || decode_fail !== efl)
        bad++;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    drain();
    n_chk++; if (error_positions_vld !== 1'b0) begin n_fail++; $display("FAIL bp_vld_drop got %b want 0", error_positions_vld); end
    n_chk++; if (error_locator_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_rise got %b want 1", error_locator_rdy); end
  endtask

  task automatic test_reset_midsearch();
    poly_t p;
    p = rand_locator(4);
    @(negedge aclk);
    error_locator = p;
    error_locator_vld = 1'b1;
    @(posedge aclk);
    #1;
    error_locator_vld = 1'b0;
    repeat (30) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_chk++; if (error_locator_rdy !== 1'b1 || error_positions_vld !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hs got rdy=%b vld=%b want rdy=1 vld=0", error_locator_rdy, error_positions_vld); end
    n_chk++; if (error_positions !== '0 || root_cnt !== '0 || decode_fail !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got %h/%0d/%b want 0/0/0", error_positions, root_cnt, decode_fail); end
    @(negedge aclk);
    aresetn = 1'b1;
    test_fixed("after_rst", rand_locator(5));
  endtask

  task automatic test_random();
    poly_t p;
    for (int n = 0; n < 8; n++) begin
      if (n == 7) begin
        p = '0;
        for (int j = 0; j <= 4; j++) p[j] = SW'($urandom_range(1, 255));
      end else begin
        p = rand_locator($urandom_range(0, TL));
      end
      test_fixed($sformatf("rand%0d", n), p);
    end
  endtask

  task automatic test_back_to_back();
    test_fixed("b2b_a", rand_locator(TL));
    test_fixed("b2b_b", rand_locator(1));
  endtask

  initial begin
    init_tables();
    test_reset();
    test_degree0();
    test_single_root();
    test_double_root();
    test_backpressure();
    test_reset_midsearch();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
